pipelined_cla_adder: RTL
========================

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter GROUP, default 4, bits per lookahead group.
REQ-003 SHALL have parameter STAGES, default 2, pipeline depth in cycles; WIDTH SHALL be a multiple of GROUP*STAGES, else elaboration error.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  operand beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port cin  input  1  carry-in (ignored when sub=1).
REQ-011 SHALL have port sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
REQ-012 SHALL have port out_valid  output  1  result beat present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 SHALL have port cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-016 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Beat transfer SHALL occur on a clk edge where valid and ready are both 1, on either side.
REQ-018 Operand slice k (bits k*WIDTH/STAGES upward, WIDTH/STAGES bits) SHALL be summed in stage k, using the registered carry out of stage k-1 (stage 0 uses cin, or 1 when sub=1).
REQ-019 Within a stage, carries SHALL be computed by group lookahead: per-bit p=a^b', g=a&b', group P/G from GROUP-bit lookahead, group carries by second-level lookahead; no ripple chain longer than one group.
REQ-020 Higher operand slices not yet summed SHALL be carried forward in stage registers with their beat.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no backpressure.
REQ-022 Throughput SHALL be one beat per cycle when out_ready is held 1.
REQ-023 Each stage SHALL advance when it is empty or the stage after it advances; last stage advances when out_ready=1 or out_valid=0.
REQ-024 in_ready SHALL equal the stage-0 advance condition, combinationally from out_ready through the stage valids (no skid buffer); in_ready SHALL be 1 whenever stage 0 is empty.
REQ-025 Bubbles SHALL collapse: an empty stage accepts data even if downstream stalls.
REQ-026 With out_valid=1 and out_ready=0, sum/cout/ovf SHALL hold stable until transfer.
REQ-027 ovf SHALL be (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), with b' = sub ? ~b : b.
REQ-028 Beats SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-029 in_valid=0 SHALL insert a bubble; operand values with in_valid=0 SHALL not affect outputs.

Reset
REQ-030 rst_n=0 SHALL asynchronously clear all stage valid bits, data registers and carry registers to 0.
REQ-031 During reset out_valid=0, sum=0, cout=0, ovf=0, in_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight beats; after release, first output is the first beat accepted after release.
REQ-033 in_ready SHALL be 1 on the first clk edge after rst_n deasserts.

Structure
REQ-034 Package cla_pkg SHALL hold the default-width constants, the group P/G struct type and the helper function computing group count.
REQ-035 Sub-module cla_group SHALL implement one combinational GROUP-bit lookahead cell (inputs p, g, c_in; outputs sum bits, group P, group G); pipelined_cla_adder SHALL instantiate it per group per stage.

Verification (WIDTH=32, GROUP=4, STAGES=2)
REQ-036 a=0xFFFFFFFF, b=0, cin=1, sub=0 -> 2 cycles later sum=0x00000000, cout=1, ovf=0.
REQ-037 a=0x7FFFFFFF, b=1, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-038 a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-039 Four back-to-back beats, out_ready=0 for 3 cycles -> in_ready drops after 2 beats accepted, all 4 results emerge in order once out_ready=1, sum stable while stalled.
REQ-040 rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, neither beat emerges; new beat after release emerges after 2 cycles.
REQ-041 Random 10k beats with random in_valid/out_ready -> every {sum,cout,ovf} matches reference model, count in = count out.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the pipelined carry-lookahead adder.
// Default geometry is a 32-bit adder split into two 16-bit stages of 4-bit groups.
package cla_pkg;

    localparam int CLA_WIDTH  = 32;
    localparam int CLA_GROUP  = 4;
    localparam int CLA_STAGES = 2;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    // Lookahead groups handled inside one pipeline stage.
    function automatic int group_count(int width, int group, int stages);
        return width / (group * stages);
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead cell: sum bits from a group carry-in, plus the
// group propagate/generate pair consumed by the second-level lookahead.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             gp,
    output logic             gg
);

    logic [GROUP-1:0] c;

    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int i = 1; i < GROUP; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
    end

    assign s  = p ^ c;
    assign gp = &p;

    always_comb begin
        gg = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gg = g[i] | (p[i] & gg);
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Valid/ready pipelined adder/subtractor: stage k sums operand slice k with
// two-level carry lookahead, forwarding unsummed operands with the beat.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = CLA_WIDTH,
    parameter int GROUP  = CLA_GROUP,
    parameter int STAGES = CLA_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW  = WIDTH / STAGES;
    localparam int NG  = group_count(WIDTH, GROUP, STAGES);
    localparam int NOP = (STAGES > 1) ? STAGES - 1 : 1;

    if (WIDTH % (GROUP * STAGES) != 0) begin : g_bad_geometry
        $error("WIDTH must be a multiple of GROUP*STAGES");
    end

    logic             rv  [STAGES];
    logic             rc  [STAGES];
    logic             adv [STAGES];
    logic [WIDTH-1:0] rs  [STAGES];
    logic [WIDTH-1:0] ra  [NOP];
    logic [WIDTH-1:0] rb  [NOP];
    logic             ro;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             iv;
        logic             ic;
        logic [WIDTH-1:0] ia;
        logic [WIDTH-1:0] ib;
        logic [WIDTH-1:0] is;
        logic [WIDTH-1:0] ns;
        logic [SW-1:0]    sp;
        logic [SW-1:0]    sg;
        logic [SW-1:0]    ss;
        logic [NG:0]      gc;
        grp_pg_t [NG-1:0] pg;

        // Subtraction folds into addition of ~b with a forced carry-in.
        if (k == 0) begin : g_head
            assign iv = in_valid;
            assign ic = sub | cin;
            assign ia = a;
            assign ib = sub ? ~b : b;
            assign is = '0;
        end else begin : g_body
            assign iv = rv[k-1];
            assign ic = rc[k-1];
            assign ia = ra[k-1];
            assign ib = rb[k-1];
            assign is = rs[k-1];
        end

        assign sp = ia[k*SW +: SW] ^ ib[k*SW +: SW];
        assign sg = ia[k*SW +: SW] & ib[k*SW +: SW];

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group #(
                .GROUP (GROUP)
            ) u_grp (
                .p    (sp[j*GROUP +: GROUP]),
                .g    (sg[j*GROUP +: GROUP]),
                .c_in (gc[j]),
                .s    (ss[j*GROUP +: GROUP]),
                .gp   (pg[j].p),
                .gg   (pg[j].g)
            );
        end

        // Flattened sum-of-products so no carry ripples between groups.
        always_comb begin
            logic t;
            logic acc;
            gc    = '0;
            gc[0] = ic;
            for (int j = 0; j < NG; j++) begin
                t = ic;
                for (int i = 0; i <= j; i++) begin
                    t = t & pg[i].p;
                end
                acc = t;
                for (int i = 0; i <= j; i++) begin
                    t = pg[i].g;
                    for (int m = i + 1; m <= j; m++) begin
                        t = t & pg[m].p;
                    end
                    acc = acc | t;
                end
                gc[j+1] = acc;
            end
        end

        always_comb begin
            ns              = is;
            ns[k*SW +: SW]  = ss;
        end

        if (k == STAGES - 1) begin : g_tail
            logic unused_ops;
            assign unused_ops = ^{ia, ib};
            assign adv[k] = !rv[k] | out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ro <= 1'b0;
                end else if (adv[k] && iv) begin
                    ro <= (ia[WIDTH-1] == ib[WIDTH-1]) &&
                          (ns[WIDTH-1] != ia[WIDTH-1]);
                end
            end
        end else begin : g_fwd
            assign adv[k] = !rv[k] | adv[k+1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra[k] <= '0;
                    rb[k] <= '0;
                end else if (adv[k] && iv) begin
                    ra[k] <= ia;
                    rb[k] <= ib;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv[k] <= 1'b0;
                rc[k] <= 1'b0;
                rs[k] <= '0;
            end else if (adv[k]) begin
                rv[k] <= iv;
                if (iv) begin
                    rc[k] <= gc[NG];
                    rs[k] <= ns;
                end
            end
        end
    end

    assign in_ready  = rst_n & adv[0];
    assign out_valid = rv[STAGES-1];
    assign sum       = rs[STAGES-1];
    assign cout      = rc[STAGES-1];
    assign ovf       = ro;

endmodule
